mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single data-memory port between the instruction-fetch requester and the load/store requester in the multi-cycle RV32I core. It grants one access at a time and registers the memory command. It counts out a fixed memory latency and returns the read data or a write acknowledge to the requester that issued the access. A starvation guard lets fetch progress under sustained load/store traffic.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- MEM_LATENCY, 2, cycles from the mem_en cycle to the mem_rdata-valid cycle; legal values are 1 or more
- STARVE_LIMIT, 4, number of consecutive contested data grants before fetch is forced; legal values are 1 or more

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held together with if_addr until granted
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid, or store complete
- d_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory command strobe; one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data; valid MEM_LATENCY cycles after mem_en

## Operation
- States:
  - IDLE: grants are possible only in this state.
  - ISSUE: one cycle; drives the memory command.
  - WAIT: latency countdown.
- IDLE behaviour:
  - With no request, stay in IDLE.
  - With a request, assert exactly one gnt, combinationally in the same cycle.
  - Latch the owner, the address, we and wdata (fetch we = 0), then go to ISSUE.
- Grant priority:
  - Data wins when both requests are high, unless starve_cnt == STARVE_LIMIT; in that case fetch wins.
  - starve_cnt increments when data is granted while if_req = 1.
  - starve_cnt clears when fetch is granted.
  - starve_cnt saturates at STARVE_LIMIT.
  - A lone request is always granted.
- ISSUE behaviour:
  - mem_en = 1, with the latched mem_we, mem_addr and mem_wdata.
  - Load lat_cnt = MEM_LATENCY-1, then go to WAIT.
- WAIT behaviour:
  - If lat_cnt == 0: assert the owner's rvalid, go to IDLE.
  - Otherwise decrement lat_cnt.
- rdata routing:
  - The owner's rdata = mem_rdata when its rvalid = 1; otherwise 0.
  - The non-owner's rdata = 0.
  - Stores still pulse d_rvalid as the completion ack, with d_rdata = mem_rdata.
- mem_en, mem_we, mem_addr and mem_wdata are registered. They are 0 outside ISSUE.
- Requesters may drop or change req and payload after the gnt cycle. The latched values are used.
- if_rvalid and d_rvalid are never high together. Each access produces exactly one rvalid.

## Timing
- Grant in cycle N.
- mem_en in cycle N+1.
- rvalid (and mem_rdata sampled) in cycle N+1+MEM_LATENCY.
- Back in IDLE in cycle N+2+MEM_LATENCY; the next grant is possible in that cycle.
- Throughput: one access per MEM_LATENCY+2 cycles.
- Reset:
  - When rst is sampled high: state = IDLE, starve_cnt = 0, lat_cnt = 0.
  - All outputs read 0 in the following cycle: gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata.
  - gnt is also forced to 0 while rst = 1.
- Reset mid-access: the in-flight access is abandoned and no rvalid is issued. A late mem_rdata is ignored.
- The first grant is possible in the first cycle with rst = 0.
- Requests raised during ISSUE or WAIT wait for IDLE. Nothing is queued beyond the held req.

## Test plan
- **Fetch read, MEM_LATENCY=2:**
  - Stimulus: if_req with if_addr = 0x100 in cycle 0.
  - Required: if_gnt in cycle 0; mem_en = 1, mem_we = 0, mem_addr = 0x100 in cycle 1.
  - Memory model returns 0xDEADBEEF: if_rvalid = 1 with if_rdata = 0xDEADBEEF in cycle 3; d_rvalid stays 0.
- **Store:**
  - Stimulus: d_req with d_we = 1, d_addr = 0x10000, d_wdata = 0x12345678 in cycle 0.
  - Required: mem_en = 1, mem_we = 1 with that address and data in cycle 1; d_rvalid in cycle 3; if_rvalid never asserted.
- **Contention:**
  - Stimulus: if_req and d_req both high in cycle 0.
  - Required: d_gnt in cycle 0; if_gnt in cycle 4; if_rvalid in cycle 7.
- **Starvation, STARVE_LIMIT=4:**
  - Stimulus: both requests held high continuously.
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt back to 0 after each I.
- **Reset mid-WAIT:**
  - Stimulus: rst = 1 in cycle 2 of a load.
  - Required: no d_rvalid; all outputs 0 from cycle 3; a new d_req is granted in the first cycle after rst drops.
- **MEM_LATENCY=1, back-to-back fetches:**
  - Stimulus: if_req held continuously.
  - Required: grants in cycles 0, 3, 6; rvalid in cycles 2, 5, 8.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between instruction fetch and
// load/store. One access in flight at a time: grant in IDLE, register the
// memory command for a single ISSUE cycle, count out the fixed latency in
// WAIT, then hand mem_rdata (or a store ack) back to the requester that owns
// the access. A saturating starvation counter lets fetch win after
// STARVE_LIMIT consecutive contested data grants.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

    logic [1:0]            state_reg, state_next;
    logic                  owner_reg;          // 1 = load/store owns the access
    logic [LAT_W-1:0]      lat_cnt_reg;
    logic [STV_W-1:0]      starve_cnt_reg;
    logic                  mem_en_reg, mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;

    logic starved, idle_ok, if_gnt_int, d_gnt_int, done;

    // Grant decision: data has priority unless fetch has been starved.
    always_comb begin
        starved    = (starve_cnt_reg == STV_LIMIT);
        idle_ok    = !rst && (state_reg == ST_IDLE);
        if_gnt_int = idle_ok && if_req && (!d_req || starved);
        d_gnt_int  = idle_ok && d_req && !(if_req && starved);
        done       = !rst && (state_reg == ST_WAIT) && (lat_cnt_reg == '0);
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (if_gnt_int || d_gnt_int) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (lat_cnt_reg == '0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, latched command, latency and starvation counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            lat_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;

            // The command registers double as the payload latch; they only
            // carry a value during the single ISSUE cycle.
            mem_en_reg    <= if_gnt_int || d_gnt_int;
            mem_we_reg    <= d_gnt_int && d_we;
            mem_addr_reg  <= if_gnt_int ? if_addr : (d_gnt_int ? d_addr : '0);
            mem_wdata_reg <= d_gnt_int ? d_wdata : '0;

            if (if_gnt_int || d_gnt_int) owner_reg <= d_gnt_int;

            if (state_reg == ST_ISSUE)
                lat_cnt_reg <= LAT_LOAD;
            else if (state_reg == ST_WAIT && lat_cnt_reg != '0)
                lat_cnt_reg <= lat_cnt_reg - 1'b1;

            if (if_gnt_int)
                starve_cnt_reg <= '0;
            else if (d_gnt_int && if_req && !starved)
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    assign if_gnt    = if_gnt_int;
    assign d_gnt     = d_gnt_int;
    assign if_rvalid = done && !owner_reg;
    assign d_rvalid  = done && owner_reg;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule
